timecounter_ar: RTL

//  Parametrised successor of the HH:MM:SS time-of-day counter. Counts seconds, minutes
//  and hours from a 1 Hz strobe. Adds three things: press-and-hold auto-repeat on inc/dec
//  in edit mode, a range-checked parallel load port, and a 12 h display view (pm flag).

---
 rtl/timecounter_ar_if.sv | 31 +++
 rtl/timecounter_ar.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/timecounter_ar_if.sv
// Time-of-day counter bus: strobes, edit controls, load port and time/display outputs.
// master drives the controls and observes the time; slave is the counter.
interface timecounter_ar_if;
  logic       tick1Hz;
  logic       freeze;
  logic       inc;
  logic       dec;
  logic [1:0] sel;
  logic       mode12;
  logic       load;
  logic [5:0] ld_ss;
  logic [5:0] ld_mm;
  logic [4:0] ld_hh;
  logic [5:0] ss;
  logic [5:0] mm;
  logic [4:0] hh;
  logic [4:0] disp_hh;
  logic       pm;
  logic       dayroll;
  logic       load_err;

  modport master (
    output tick1Hz, freeze, inc, dec, sel, mode12, load, ld_ss, ld_mm, ld_hh,
    input  ss, mm, hh, disp_hh, pm, dayroll, load_err
  );

  modport slave (
    input  tick1Hz, freeze, inc, dec, sel, mode12, load, ld_ss, ld_mm, ld_hh,
    output ss, mm, hh, disp_hh, pm, dayroll, load_err
  );
endinterface

// File: rtl/timecounter_ar.sv
// HH:MM:SS counter with 1 Hz counting, edit mode with press-and-hold auto-repeat,
// range-checked parallel load and a 12 h display view.
module timecounter_ar #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input logic             clk,
  input logic             rst,
  timecounter_ar_if.slave bus
);
  localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, lim;
  logic             dir_l, dir_nxt;
  logic [1:0]       sel_l, sel_nxt;
  logic             req, step;

  logic [5:0] ss_q, mm_q;
  logic [4:0] hh_q;
  logic       dayroll_q, load_err_q;
  logic       ld_ok;

  assign req   = bus.freeze & (bus.inc ^ bus.dec);
  assign lim   = (state == DELAY) ? CNT_W'(REPEAT_DLY - 1) : CNT_W'(REPEAT_PER - 1);
  assign ld_ok = (bus.ld_ss <= 6'd59) && (bus.ld_mm <= 6'd59) && (bus.ld_hh <= 5'd23);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      dir_l <= 1'b0;
      sel_l <= 2'b00;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      dir_l <= dir_nxt;
      sel_l <= sel_nxt;
    end
  end

  // Any abort (release, both pressed, direction or field change) returns to IDLE without a step.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dir_nxt   = dir_l;
    sel_nxt   = sel_l;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          step      = 1'b1;
          timer_nxt = '0;
          state_nxt = DELAY;
          dir_nxt   = bus.inc;
          sel_nxt   = bus.sel;
        end
      end
      DELAY, REPEAT: begin
        if (!req || (bus.inc != dir_l) || (bus.sel != sel_l)) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == lim) begin
          step      = 1'b1;
          timer_nxt = '0;
          state_nxt = REPEAT;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q       <= '0;
      mm_q       <= '0;
      hh_q       <= '0;
      dayroll_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      dayroll_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (ld_ok) begin
          ss_q <= bus.ld_ss;
          mm_q <= bus.ld_mm;
          hh_q <= bus.ld_hh;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (bus.freeze) begin
        if (step) begin
          case (bus.sel)
            2'b01: ss_q <= dir_nxt ? ((ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1)
                                   : ((ss_q == 6'd0) ? 6'd59 : ss_q - 6'd1);
            2'b10: mm_q <= dir_nxt ? ((mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1)
                                   : ((mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1);
            2'b11: hh_q <= dir_nxt ? ((hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1)
                                   : ((hh_q == 5'd0) ? 5'd23 : hh_q - 5'd1);
            default: ;
          endcase
        end
      end else if (bus.tick1Hz) begin
        if (ss_q == 6'd59) begin
          ss_q <= 6'd0;
          if (mm_q == 6'd59) begin
            mm_q <= 6'd0;
            if (hh_q == 5'd23) begin
              hh_q      <= 5'd0;
              dayroll_q <= 1'b1;
            end else begin
              hh_q <= hh_q + 5'd1;
            end
          end else begin
            mm_q <= mm_q + 6'd1;
          end
        end else begin
          ss_q <= ss_q + 6'd1;
        end
      end
    end
  end

  assign bus.ss       = ss_q;
  assign bus.mm       = mm_q;
  assign bus.hh       = hh_q;
  assign bus.dayroll  = dayroll_q;
  assign bus.load_err = load_err_q;
  // 12 h view: midnight and noon both read 12.
  assign bus.disp_hh  = !bus.mode12     ? hh_q :
                        (hh_q == 5'd0)  ? 5'd12 :
                        (hh_q > 5'd12)  ? hh_q - 5'd12 : hh_q;
  assign bus.pm       = bus.mode12 & (hh_q >= 5'd12);
endmodule
